mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
- Streaming signed multiply-accumulate stage directly upstream of the fixed-point formatter.
- Multiplies pairs of Q6.9 operands and accumulates each vector of products into a saturating WIDTH_ACC-bit Q.18 sum.
- On the last element of a vector, it presents the sum, held under a valid/ready handshake, for the formatter to round and saturate back to 16 bits.
- Two-stage pipeline with full backpressure.

Parameters:
- WIDTH_DATA, 16, operand width (signed two's complement, Q6.9).
- WIDTH_ACC, 32, accumulator and result width. Must be >= 2*WIDTH_DATA.
- WIDTH_CNT, 10, width of the per-vector element counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- a_i  input  WIDTH_DATA  operand A, signed.
- b_i  input  WIDTH_DATA  operand B, signed.
- in_valid_i  input  1  operand pair valid.
- in_last_i  input  1  pair is the final element of the current vector; qualified by in_valid_i.
- in_ready_o  output  1  stage can accept a pair this cycle.
- acc_o  output  WIDTH_ACC  accumulated vector result, signed Q.18; feeds the formatter's data_i.
- acc_sat_o  output  1  result was clamped at least once during this vector.
- acc_cnt_o  output  WIDTH_CNT  number of elements in this vector; saturates at all-ones.
- acc_valid_o  output  1  result valid.
- acc_ready_i  input  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync-released on clk_i):
  - p1_valid, acc register, sat flag and element counter go to 0.
  - acc_o = 0, acc_sat_o = 0, acc_cnt_o = 0, acc_valid_o = 0.
  - Any partially accumulated vector and any pending result are discarded.
- Global advance: adv = !acc_valid_o | acc_ready_i. in_ready_o = adv; it is purely combinational from registered state and acc_ready_i.
- Stage 1 (on adv):
  - p1_prod <= sign-extended a_i*b_i (full 2*WIDTH_DATA product).
  - p1_last <= in_last_i.
  - p1_valid <= in_valid_i.
  - When adv = 0, stage 1 holds.
- Stage 2 (on adv and p1_valid):
  - sum = acc + p1_prod, computed at WIDTH_ACC+1 bits.
  - If sum exceeds the signed WIDTH_ACC range, clamp to max (0x7FFFFFFF) or min (0x80000000) and set sat.
  - Counter increments, saturating at 2^WIDTH_CNT-1.
  - If p1_last = 0: acc <= clamped sum; sat and counter update.
  - If p1_last = 1:
    - acc_o <= clamped sum; acc_sat_o <= sat | this-step overflow; acc_cnt_o <= counter+1 (saturating); acc_valid_o <= 1.
    - acc, sat and counter clear to 0 in the same edge, so the next vector starts at zero with no bubble.
- Output handshake:
  - acc_valid_o and acc_o/acc_sat_o/acc_cnt_o stay stable until an edge with acc_ready_i = 1.
  - On that edge acc_valid_o drops unless a new last element completes in the same edge, in which case the new result loads (back-to-back results allowed).
- Latency: a last pair accepted at edge N produces acc_valid_o = 1 after edge N+1. Throughput is 1 pair/cycle while acc_ready_i = 1.
- Stall: when acc_valid_o = 1 and acc_ready_i = 0, both stages freeze, including a non-last p1. No pair is dropped or duplicated.
- Single-element vector (in_last_i on the first pair): result = product, acc_cnt_o = 1.
- in_last_i is ignored when in_valid_i = 0. A bubble in stage 1 does not change acc.
- Saturation is sticky only within a vector. Once clamped, later products continue from the clamped value.

Test Plan:
- Reset mid-vector: feed 3 non-last pairs, then deassert rst_ni for 1 cycle. Required: acc_valid_o = 0; a following single pair a = 512, b = 512 (1.0 × 1.0), last, gives acc_o = 0x00040000, acc_cnt_o = 1.
- Dot product, acc_ready_i = 1: a = {512, -1024, 256}, b = {512, 512, -512}, last on the third pair. Required: acc_o = 262144 - 524288 - 131072 = -393216 (0xFFFA0000), acc_sat_o = 0, acc_cnt_o = 3, valid 2 cycles after the last accept.
- Back-to-back vectors: two 1-element vectors on consecutive cycles (a = 3, b = 5, then a = -2, b = 7). Required: acc_o = 15 then -14 on consecutive cycles, with no carry-over between vectors.
- Backpressure: hold acc_ready_i = 0 for 5 cycles with result pending. Required: in_ready_o = 0, acc_o stable; after release, the next vector is processed without loss.
- Positive saturation: 40 pairs of a = b = -32768 (2^30 each). Required: acc_o = 0x7FFFFFFF, acc_sat_o = 1, acc_cnt_o = 40.
- Negative saturation: 3 pairs of a = -32768, b = 32767. Required: acc_o = 0x80000000, acc_sat_o = 1. The next vector with a = b = 1 gives acc_o = 1, acc_sat_o = 0.

Source files
------------

// File: rtl/mac_accumulator.sv
// Streaming signed multiply-accumulate stage feeding the fixed-point formatter.
// Stage 1 registers the full Q6.9 x Q6.9 product. Stage 2 folds that product
// into a saturating Q.18 running sum. When the product is the last element of
// a vector, stage 2 publishes the sum under a valid/ready handshake.
// Both stages advance together, so a stalled result freezes the whole pipe.
module mac_accumulator #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_ACC  = 32,
  parameter int WIDTH_CNT  = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WIDTH_DATA-1:0] a_i,
  input  logic [WIDTH_DATA-1:0] b_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [WIDTH_ACC-1:0]  acc_o,
  output logic                  acc_sat_o,
  output logic [WIDTH_CNT-1:0]  acc_cnt_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i
);

  localparam logic [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

  logic                          adv;
  logic                          step;
  logic signed [2*WIDTH_DATA-1:0] prodFull;
  logic signed [WIDTH_ACC-1:0]   prodExt;
  logic signed [WIDTH_ACC:0]     sumWide;
  logic                          overflow;
  logic [WIDTH_ACC-1:0]          clamped_d;
  logic [WIDTH_CNT-1:0]          cntInc_d;

  logic signed [WIDTH_ACC-1:0]   p1Prod_q;
  logic                          p1Last_q;
  logic                          p1Valid_q;
  logic signed [WIDTH_ACC-1:0]   accum_q;
  logic                          sat_q;
  logic [WIDTH_CNT-1:0]          cnt_q;
  logic [WIDTH_ACC-1:0]          accOut_q;
  logic                          accSat_q;
  logic [WIDTH_CNT-1:0]          accCnt_q;
  logic                          accValid_q;

  // The pipe moves whenever no result is waiting or the waiting result is taken.
  assign adv        = !accValid_q || acc_ready_i;
  assign step       = adv && p1Valid_q;
  assign in_ready_o = adv;

  assign acc_o       = accOut_q;
  assign acc_sat_o   = accSat_q;
  assign acc_cnt_o   = accCnt_q;
  assign acc_valid_o = accValid_q;

  // Signed product, sign-extended to accumulator width, plus the one-bit-wider sum, clamp and counter increment.
  always_comb begin
    prodFull  = '0;
    prodExt   = '0;
    sumWide   = '0;
    overflow  = 1'b0;
    clamped_d = '0;
    cntInc_d  = cnt_q;

    prodFull = $signed(a_i) * $signed(b_i);
    prodExt  = WIDTH_ACC'(prodFull);

    sumWide  = (WIDTH_ACC+1)'(accum_q) + (WIDTH_ACC+1)'(p1Prod_q);
    overflow = sumWide[WIDTH_ACC] ^ sumWide[WIDTH_ACC-1];
    if (overflow) begin
      clamped_d = sumWide[WIDTH_ACC] ? ACC_MIN : ACC_MAX;
    end else begin
      clamped_d = sumWide[WIDTH_ACC-1:0];
    end

    if (!(&cnt_q)) begin
      cntInc_d = cnt_q + WIDTH_CNT'(1);
    end
  end

  // Stage 1 captures the product of the incoming pair. The last flag only counts when the pair is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p1Prod_q  <= '0;
      p1Last_q  <= 1'b0;
      p1Valid_q <= 1'b0;
    end else if (adv) begin
      p1Prod_q  <= prodExt;
      p1Last_q  <= in_last_i && in_valid_i;
      p1Valid_q <= in_valid_i;
    end
  end

  // Stage 2 accumulates the products. On the last element it publishes the result and clears the running state, so the next vector starts without a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accum_q    <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      accOut_q   <= '0;
      accSat_q   <= 1'b0;
      accCnt_q   <= '0;
      accValid_q <= 1'b0;
    end else begin
      if (adv) begin
        accValid_q <= p1Valid_q && p1Last_q;
      end
      if (step) begin
        if (p1Last_q) begin
          accOut_q <= clamped_d;
          accSat_q <= sat_q || overflow;
          accCnt_q <= cntInc_d;
          accum_q  <= '0;
          sat_q    <= 1'b0;
          cnt_q    <= '0;
        end else begin
          accum_q  <= clamped_d;
          sat_q    <= sat_q || overflow;
          cnt_q    <= cntInc_d;
        end
      end
    end
  end

endmodule
